row_source_controller: RTL and testbench

- Runtime controller for the display row datapath. It parses ASCII commands from the UART receiver and maintains a row-to-source map.
- It drives the per-row character multiplexer feeding the text engine, and the pixel/text select feeding the screen.
- It replaces the fixed rowNumber case statement, so any of four character sources, the progress-bar pixel source, or blank can be assigned to any of the four rows.

---
 rtl/row_source_controller.sv | 166 ++++++++++++++++
 tb/tb_row_source_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/row_source_controller.sv
// Command-driven row-to-source map for the display row datapath: parses ASCII
// "S r s" / "D" commands from the UART and drives the per-row character mux.
module row_source_controller #(
  parameter int          TIMEOUT_CYCLES = 5000000,
  parameter logic [11:0] DEFAULT_MAP    = 12'h888
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byteReady,
  input  logic [7:0]  data,
  input  logic [1:0]  rowNumber,
  input  logic [7:0]  charIn0,
  input  logic [7:0]  charIn1,
  input  logic [7:0]  charIn2,
  input  logic [7:0]  charIn3,
  output logic [7:0]  charOutput,
  output logic        usePixelSource,
  output logic [11:0] rowMap,
  output logic        cmdOk,
  output logic        cmdErr,
  output logic        busy
);

  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    GOT_S,
    GOT_ROW,
    GOT_SRC,
    GOT_D,
    FLUSH
  } state_t;

  state_t        state_reg, state_next;
  logic [1:0]    row_reg, row_next;
  logic [2:0]    src_reg, src_next;
  logic [11:0]   map_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          ok_next, err_next;

  logic is_term, is_s, is_d, is_row_digit, is_src_digit, timeout;
  logic [2:0] lookup_code;

  assign is_term      = (data == 8'h0D) || (data == 8'h0A);
  assign is_s         = (data == 8'h53) || (data == 8'h73);
  assign is_d         = (data == 8'h44) || (data == 8'h64);
  assign is_row_digit = (data >= 8'h30) && (data <= 8'h33);
  assign is_src_digit = (data >= 8'h30) && (data <= 8'h35);
  assign timeout      = (state_reg != IDLE) && (cnt_reg == TIMEOUT_VAL);

  assign lookup_code    = rowMap[3*rowNumber +: 3];
  assign usePixelSource = (lookup_code == 3'd4);
  assign busy           = (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    src_next   = src_reg;
    map_next   = rowMap;
    ok_next    = 1'b0;
    err_next   = 1'b0;

    if (state_reg == IDLE || byteReady)
      cnt_next = '0;
    else if (cnt_reg != TIMEOUT_VAL)
      cnt_next = cnt_reg + 1'b1;
    else
      cnt_next = cnt_reg;

    // Timeout wins over a byte arriving in the same cycle; that byte is dropped.
    if (timeout) begin
      state_next = IDLE;
      err_next   = 1'b1;
      cnt_next   = '0;
    end else if (byteReady) begin
      case (state_reg)
        IDLE: begin
          if (is_s)          state_next = GOT_S;
          else if (is_d)     state_next = GOT_D;
          else if (!is_term) state_next = FLUSH;
        end
        GOT_S: begin
          if (is_row_digit) begin
            row_next   = data[1:0];
            state_next = GOT_ROW;
          end else begin
            state_next = is_term ? IDLE : FLUSH;
            err_next   = is_term;
          end
        end
        GOT_ROW: begin
          if (is_src_digit) begin
            src_next   = data[2:0];
            state_next = GOT_SRC;
          end else begin
            state_next = is_term ? IDLE : FLUSH;
            err_next   = is_term;
          end
        end
        GOT_SRC: begin
          if (is_term) begin
            map_next[3*row_reg +: 3] = src_reg;
            ok_next    = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = FLUSH;
          end
        end
        GOT_D: begin
          if (is_term) begin
            map_next   = DEFAULT_MAP;
            ok_next    = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = FLUSH;
          end
        end
        FLUSH: begin
          if (is_term) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      row_reg   <= '0;
      src_reg   <= '0;
      rowMap    <= DEFAULT_MAP;
      cnt_reg   <= '0;
      cmdOk     <= 1'b0;
      cmdErr    <= 1'b0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      src_reg   <= src_next;
      rowMap    <= map_next;
      cnt_reg   <= cnt_next;
      cmdOk     <= ok_next;
      cmdErr    <= err_next;
    end
  end

  // Lookup uses the map as it stood before this edge's write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      charOutput <= 8'h00;
    end else begin
      case (lookup_code)
        3'd0:    charOutput <= charIn0;
        3'd1:    charOutput <= charIn1;
        3'd2:    charOutput <= charIn2;
        3'd3:    charOutput <= charIn3;
        default: charOutput <= 8'h20;
      endcase
    end
  end

endmodule

// File: tb/tb_row_source_controller.sv
// Directed and randomized command streams checked against a string-level
// command model of the row map.
module tb_row_source_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        byteReady;
  logic [7:0]  data;
  logic [1:0]  rowNumber;
  logic [7:0]  charIn0, charIn1, charIn2, charIn3;
  logic [7:0]  charOutput;
  logic        usePixelSource;
  logic [11:0] rowMap;
  logic        cmdOk, cmdErr, busy;

  int passed = 0;
  int total  = 0;

  logic [7:0] chars [4];
  int         model_map [4];
  byte        pending [$];

  always #5 clk = ~clk;

  assign charIn0 = chars[0];
  assign charIn1 = chars[1];
  assign charIn2 = chars[2];
  assign charIn3 = chars[3];

  row_source_controller #(
    .TIMEOUT_CYCLES(100),
    .DEFAULT_MAP   (12'h888)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .byteReady     (byteReady),
    .data          (data),
    .rowNumber     (rowNumber),
    .charIn0       (charIn0),
    .charIn1       (charIn1),
    .charIn2       (charIn2),
    .charIn3       (charIn3),
    .charOutput    (charOutput),
    .usePixelSource(usePixelSource),
    .rowMap        (rowMap),
    .cmdOk         (cmdOk),
    .cmdErr        (cmdErr),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic void model_default();
    model_map[0] = 0;
    model_map[1] = 1;
    model_map[2] = 2;
    model_map[3] = 4;
  endfunction

  function automatic logic [11:0] model_packed();
    logic [11:0] m;
    for (int r = 0; r < 4; r++) m[3*r +: 3] = 3'(model_map[r]);
    return m;
  endfunction

  function automatic bit is_term(input byte b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  // Judge a whole terminated command line: empty lines are ignored.
  function automatic void model_line(output bit ok, output bit err);
    ok  = 0;
    err = 0;
    if (pending.size() == 0) return;
    if (pending.size() == 3 && (pending[0] == "S" || pending[0] == "s") &&
        pending[1] >= "0" && pending[1] <= "3" && pending[2] >= "0" && pending[2] <= "5") begin
      model_map[pending[1] - 8'h30] = pending[2] - 8'h30;
      ok = 1;
    end else if (pending.size() == 1 && (pending[0] == "D" || pending[0] == "d")) begin
      model_default();
      ok = 1;
    end else begin
      err = 1;
    end
    pending.delete();
  endfunction

  task automatic send_byte(input byte b);
    bit exp_ok, exp_err;
    exp_ok  = 0;
    exp_err = 0;
    if (is_term(b)) model_line(exp_ok, exp_err);
    else pending.push_back(b);
    @(negedge clk);
    data      = b;
    byteReady = 1'b1;
    @(posedge clk);
    #1;
    byteReady = 1'b0;
    $display("byte %02h ok=%0b err=%0b busy=%0b map=%03h", b, cmdOk, cmdErr, busy, rowMap);
    chk("cmd_ok", 32'(cmdOk), 32'(exp_ok));
    chk("cmd_err", 32'(cmdErr), 32'(exp_err));
    chk("busy", 32'(busy), 32'(pending.size() != 0));
    chk("row_map", 32'(rowMap), 32'(model_packed()));
    @(posedge clk);
    #1;
    chk("pulse_width", 32'({cmdOk, cmdErr}), 32'(0));
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic check_row(input int r);
    logic [7:0] exp_char;
    @(negedge clk);
    rowNumber = 2'(r);
    @(posedge clk);
    #1;
    exp_char = (model_map[r] < 4) ? chars[model_map[r]] : 8'h20;
    $display("row %0d char=%02h pix=%0b", r, charOutput, usePixelSource);
    chk("char_out", 32'(charOutput), 32'(exp_char));
    chk("pixel_sel", 32'(usePixelSource), 32'(model_map[r] == 4));
  endtask

  task automatic sweep_rows();
    for (int r = 0; r < 4; r++) check_row(r);
  endtask

  initial begin
    int n;
    int kind;
    byte t;
    string s;

    rst       = 1'b1;
    byteReady = 1'b0;
    data      = 8'h00;
    rowNumber = 2'd0;
    chars[0] = 8'h41; chars[1] = 8'h42; chars[2] = 8'h43; chars[3] = 8'h44;
    model_default();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_map", 32'(rowMap), 32'h888);
    chk("rst_char", 32'(charOutput), 32'h00);
    chk("rst_flags", 32'({cmdOk, cmdErr, busy}), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    sweep_rows();

    send_str("S05\r");
    send_str("S34\n");
    chk("map_88d", 32'(rowMap), 32'h88D);
    sweep_rows();

    send_str("S14\r\n");
    send_str("S23\r");
    sweep_rows();

    send_str("S7");
    send_str("2\r");
    send_str("X\r");
    chk("busy_idle", 32'(busy), 32'(0));

    // Stalled command: "S2" then silence until the timeout fires.
    send_str("S");
    @(negedge clk);
    data      = "2";
    byteReady = 1'b1;
    @(posedge clk);
    #1;
    byteReady = 1'b0;
    n = 0;
    while (n < 300 && cmdErr !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    $display("timeout after %0d cycles busy=%0b map=%03h", n, busy, rowMap);
    chk("timeout_cycle", 32'(n >= 100 && n <= 101), 32'(1));
    chk("timeout_busy", 32'(busy), 32'(0));
    chk("timeout_map", 32'(rowMap), 32'(model_packed()));
    pending.delete();
    @(posedge clk);
    #1;
    chk("timeout_pulse", 32'(cmdErr), 32'(0));
    send_str("S21\r");
    sweep_rows();

    // Reset in the middle of a command.
    send_str("S02");
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_default();
    pending.delete();
    $display("mid-command reset map=%03h busy=%0b", rowMap, busy);
    chk("midrst_map", 32'(rowMap), 32'h888);
    chk("midrst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    send_str("D\r");
    sweep_rows();

    // Randomized command lines with random gaps and source data.
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 5);
      s = "";
      case (kind)
        0, 1, 2: begin
          s = {s, ($urandom_range(0, 1) != 0) ? "S" : "s"};
          s = {s, 8'(8'h30 + $urandom_range(0, 3))};
          s = {s, 8'(8'h30 + $urandom_range(0, 5))};
        end
        3: s = ($urandom_range(0, 1) != 0) ? "D" : "d";
        4: begin
          for (int k = 0; k < $urandom_range(1, 4); k++) s = {s, 8'($urandom_range(8'h21, 8'h7E))};
        end
        default: begin
          s = {s, "S"};
          s = {s, 8'(8'h30 + $urandom_range(0, 9))};
          s = {s, 8'(8'h30 + $urandom_range(0, 9))};
        end
      endcase
      t = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
      send_str(s);
      send_byte(t);
      if ($urandom_range(0, 3) == 0) send_byte(8'h0A);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < 4; k++) chars[k] = 8'($urandom);
        check_row($urandom_range(0, 3));
      end
    end
    sweep_rows();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
